// File: rtl/muldiv_unit_pkg.sv
// RV32M multiply/divide shared constants.
// funct3 op encodings, FSM states and operand signedness helpers.
package muldiv_unit_pkg;

  localparam logic [2:0] MUL_F3    = 3'd0;
  localparam logic [2:0] MULH_F3   = 3'd1;
  localparam logic [2:0] MULHSU_F3 = 3'd2;
  localparam logic [2:0] MULHU_F3  = 3'd3;
  localparam logic [2:0] DIV_F3    = 3'd4;
  localparam logic [2:0] DIVU_F3   = 3'd5;
  localparam logic [2:0] REM_F3    = 3'd6;
  localparam logic [2:0] REMU_F3   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic a_signed(input logic [2:0] f);
    return (f == MULH_F3) || (f == MULHSU_F3) ||
           (f == DIV_F3)  || (f == REM_F3);
  endfunction

  function automatic logic b_signed(input logic [2:0] f);
    return (f == MULH_F3) || (f == DIV_F3) ||
           (f == REM_F3);
  endfunction

endpackage

// File: rtl/muldiv_unit_register.sv
// Plain enabled register with synchronous active-high reset.
// Holds the muldiv result between done pulses.
module muldiv_unit_register #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (ena)
      q <= d;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One shift-add or shift-subtract step per clock over operand magnitudes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [BUS_WIDTH-1:0] opA,
  input  logic [BUS_WIDTH-1:0] opB,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W);

  state_t r_state;
  state_t w_next;

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_b;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_op;
  logic           r_nega;
  logic           r_negq;
  logic           r_bz;
  logic           r_done;

  logic           w_na;
  logic           w_nb;
  logic [W-1:0]   w_maga;
  logic [W-1:0]   w_magb;
  logic [W:0]     w_addend;
  logic [W:0]     w_sum;
  logic [W:0]     w_trial;
  logic [2*W-1:0] w_mul_nxt;
  logic [2*W-1:0] w_div_nxt;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_qmag;
  logic [W-1:0]   w_rmag;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_res;
  logic           w_fix;

  assign w_na   = a_signed(funct3) & opA[W-1];
  assign w_nb   = b_signed(funct3) & opB[W-1];
  assign w_maga = w_na ? -opA : opA;
  assign w_magb = w_nb ? -opB : opB;

  // multiply: acc = {partial high, multiplier bits shifting out}
  assign w_addend  = r_acc[0] ? {1'b0, r_b} : '0;
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + w_addend;
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};

  // divide: acc = {partial remainder, dividend/quotient bits}
  assign w_trial   = r_acc[2*W-1:W-1] - {1'b0, r_b};
  assign w_div_nxt = w_trial[W]
                   ? {r_acc[2*W-2:0], 1'b0}
                   : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_nega <= 1'b0;
      r_negq <= 1'b0;
      r_bz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= {{W{1'b0}}, w_maga};
            r_b    <= w_magb;
            r_cnt  <= CW'(W - 1);
            r_op   <= funct3;
            r_nega <= w_na;
            r_negq <= w_na ^ w_nb;
            r_bz   <= (opB == '0);
          end
        end
        S_RUN: begin
          r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // a zero divisor leaves remainder = |A|, so the sign fix restores opA
  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_qmag = r_acc[W-1:0];
  assign w_rmag = r_acc[2*W-1:W];
  assign w_quo  = r_bz ? '1 : (r_negq ? -w_qmag : w_qmag);
  assign w_rem  = r_nega ? -w_rmag : w_rmag;

  always_comb begin
    w_res = w_rem;
    unique case (r_op)
      MUL_F3:    w_res = w_prod[W-1:0];
      MULH_F3:   w_res = w_prod[2*W-1:W];
      MULHSU_F3: w_res = w_prod[2*W-1:W];
      MULHU_F3:  w_res = w_prod[2*W-1:W];
      DIV_F3:    w_res = w_quo;
      DIVU_F3:   w_res = w_quo;
      default:   w_res = w_rem;
    endcase
  end

  assign w_fix = (r_state == S_FIX);

  muldiv_unit_register #(.N(W)) u_res (
    .clk (clk),
    .rst (rst),
    .ena (w_fix),
    .d   (w_res),
    .q   (result)
  );

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus
// handshake, back-to-back and mid-op reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  muldiv_unit #(.BUS_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b,
                        output logic [31:0] res, output int cyc);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    opA    = a;
    opB    = b;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    opA    = $urandom;
    opB    = $urandom;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] r;
    int          cyc;
    int          ndone;

    vecs[0]  = '{"mul_7x-3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{"mulh_min2",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2]  = '{"mulhsu_min2",   3'd2, 32'h80000000, 32'h80000000, 32'hC0000000};
    vecs[3]  = '{"mulhu_min2",    3'd3, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4]  = '{"div_-7/2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{"rem_-7/2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{"divu_100/7",    3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{"remu_100/7",    3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{"div_by0",       3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{"divu_by0",      3'd5, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
    vecs[10] = '{"rem_by0",       3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[11] = '{"remu_by0",      3'd7, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
    vecs[12] = '{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[14] = '{"mul_shift",     3'd0, 32'h12345678, 32'h00000010, 32'h23456780};
    vecs[15] = '{"mulhu_max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[16] = '{"mulh_-1x-1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[17] = '{"mulhsu_-1xmax", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[18] = '{"divu_max/1",    3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[19] = '{"div_-7/-2",     3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3};

    rst    = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    opA    = '0;
    opB    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result,        32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, cyc);
      chk(vecs[i].nm, r, vecs[i].exp);
      chk({vecs[i].nm, "_lat"}, 32'(cyc), 32'd33);
    end

    // start held high, operands toggling while busy
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    opA    = 32'd3;
    opB    = 32'd5;
    @(negedge clk);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    opA = $urandom;
    opB = $urandom;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        opA = $urandom;
        opB = $urandom;
      end
    end
    chk("hold_res1", result, 32'd15);
    chk("hold_lat1", 32'(cyc), 32'd33);
    opA = 32'd4;
    opB = 32'd5;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    opA = $urandom;
    opB = $urandom;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        opA = $urandom;
        opB = $urandom;
      end
    end
    chk("b2b_res2", result, 32'd20);
    chk("b2b_lat2", 32'(cyc), 32'd33);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // reset mid-operation
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    opA    = 32'd2;
    opB    = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    chk("abort_done",   {31'd0, done}, 32'd0);
    chk("abort_result", result,        32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
